serial_add_ctrl: RTL and testbench

//  Bit-serial sequencer that sits directly around the single-bit full-adder cell.
//  - Feeds the cell's a/b/ci inputs one bit per clock, LSB first.
//  - Consumes the cell's s/co outputs: s is shifted into the result register, co into the carry flop.
//  - Produces a WIDTH-bit sum plus carry-out after WIDTH clocks, using one full-adder cell.

---
 rtl/serial_add_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add sequencer wrapped around one external
// full-adder cell. Operands are fed LSB first, one bit per clock; the cell's
// sum bit is shifted into the result register and its carry is fed back.
// Optional build macro: SERIAL_ADD_SUB_EN adds a 'sub' input that turns the
// operation into a - b (b inverted, carry-in forced to 1).
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_ci,
   input  logic             fa_s,
   input  logic             fa_co
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] sum_r;
   logic [CW-1:0]    count_r;
   logic             carry_r;
   logic             cout_r;
   logic             busy_r;
   logic             done_r;

   logic [WIDTH-1:0] b_load_s;
   logic             carry_init_s;

   // Select the B operand image and initial carry loaded at start
   always_comb begin
      b_load_s     = b_in;
      carry_init_s = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      if (sub) begin
         b_load_s     = ~b_in;
         carry_init_s = 1'b1;
      end else begin
         b_load_s     = b_in;
         carry_init_s = 1'b0;
      end
`endif
   end

   // Drive the full-adder cell inputs; quiet (all zero) outside SHIFT
   always_comb begin
      if (state_r == ST_SHIFT) begin
         fa_a  = a_sh_r[0];
         fa_b  = b_sh_r[0];
         fa_ci = carry_r;
      end else begin
         fa_a  = 1'b0;
         fa_b  = 1'b0;
         fa_ci = 1'b0;
      end
   end

   // Sequencer FSM with all datapath registers and registered status outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         a_sh_r  <= {WIDTH{1'b0}};
         b_sh_r  <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         count_r <= {CW{1'b0}};
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  a_sh_r  <= a_in;
                  b_sh_r  <= b_load_s;
                  carry_r <= carry_init_s;
                  count_r <= {CW{1'b0}};
                  sum_r   <= {WIDTH{1'b0}};
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  state_r <= ST_SHIFT;
               end else begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               // Result fills from the top so bit 0 ends up in sum[0]
               sum_r   <= {fa_s, sum_r[WIDTH-1:1]};
               carry_r <= fa_co;
               a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
               b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
               count_r <= count_r + CW'(1);
               if (count_r == CW'(WIDTH - 1)) begin
                  cout_r  <= fa_co;
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  state_r <= ST_SHIFT;
               end
            end
            ST_DONE: begin
               // start is deliberately ignored here; next accept is in IDLE
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign sum  = sum_r;
   assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a behavioural full-adder cell
// closes the loop; table vectors, corner sequences and random operations
// are checked against an arithmetic reference model.
module tb_serial_add_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
`ifdef SERIAL_ADD_SUB_EN
   logic         sub = 1'b0;
`endif
   logic         busy, done, cout, fa_a, fa_b, fa_ci, fa_s, fa_co;
   logic [W-1:0] sum;

   int n_vec = 0;
   int n_err = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SERIAL_ADD_SUB_EN
      .sub(sub),
`endif
      .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .sum(sum),
      .cout(cout), .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci),
      .fa_s(fa_s), .fa_co(fa_co)
   );

   // behavioural single-bit full adder cell
   assign fa_s  = fa_a ^ fa_b ^ fa_ci;
   assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sb;
      logic [W-1:0] s;
      logic         c;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference: plain arithmetic on the operands
   function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb);
      logic [W-1:0] d;
      if (sb) begin
         d = a - b;
         return {(a >= b) ? 1'b1 : 1'b0, d};
      end
      return {1'b0, a} + {1'b0, b};
   endfunction

   // reference: carry entering bit k = carry out of the low k bits
   function automatic logic [W-1:0] ref_ci(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb);
      logic [W-1:0] r;
      int unsigned  bb, mask, v;
      bb = sb ? int'(~b) : int'(b);
      for (int k = 0; k < W; k++) begin
         mask = (32'd1 << k) - 32'd1;
         v    = (int'(a) & mask) + (bb & mask) + (sb ? 32'd1 : 32'd0);
         r[k] = v[k];
      end
      return r;
   endfunction

   // One full operation: accept, scramble inputs while busy, check all
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                        input string tag, output logic [W-1:0] got_s, output logic got_c);
      logic [W-1:0] ci_h, a_h, b_h, bx;
      logic [W:0]   exp;
      int           lat;
      ci_h = '0; a_h = '0; b_h = '0;
      a_in = a; b_in = b;
`ifdef SERIAL_ADD_SUB_EN
      sub = sb;
`endif
      start = 1'b1;
      step();
      start = 1'b0;
      lat = 0;
      while (!done && lat < 3 * W) begin
         if (lat < W) begin
            ci_h[lat] = fa_ci;
            a_h[lat]  = fa_a;
            b_h[lat]  = fa_b;
         end
         a_in = W'($urandom);
         b_in = W'($urandom);
         step();
         lat++;
      end
      exp  = ref_result(a, b, sb);
      bx   = sb ? ~b : b;
      got_s = sum;
      got_c = cout;
      chk({tag, " latency"}, lat, W);
      chk({tag, " sum"}, sum, exp[W-1:0]);
      chk({tag, " cout"}, cout, exp[W]);
      chk({tag, " fa_ci seq"}, ci_h, ref_ci(a, b, sb));
      chk({tag, " fa_a seq"}, a_h, a);
      chk({tag, " fa_b seq"}, b_h, bx);
      step();
      chk({tag, " done one cycle"}, {busy, done}, 2'b00);
      chk({tag, " sum held"}, sum, exp[W-1:0]);
   endtask

   initial begin
      vec_t         tbl[$];
      logic [W-1:0] gs;
      logic         gc;
      int           dones;
      bit           sb;

      // ---------------- reset ----------------
      step();
      step();
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset sum", sum, 8'h00);
      chk("reset cout", cout, 1'b0);
      chk("reset fa", {fa_a, fa_b, fa_ci}, 3'b000);
      rst_n = 1'b1;
      step();

      // ---------------- table vectors ----------------
      tbl.push_back('{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0});
      tbl.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
      tbl.push_back('{8'h12, 8'h34, 1'b0, 8'h46, 1'b0});
      tbl.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
      tbl.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
      tbl.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
`ifdef SERIAL_ADD_SUB_EN
      tbl.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
      tbl.push_back('{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0});
      tbl.push_back('{8'h55, 8'h55, 1'b1, 8'h00, 1'b1});
`endif
      for (int i = 0; i < tbl.size(); i++) begin
         do_op(tbl[i].a, tbl[i].b, tbl[i].sb, $sformatf("tbl%0d", i), gs, gc);
         chk($sformatf("tbl%0d const sum", i), gs, tbl[i].s);
         chk($sformatf("tbl%0d const cout", i), gc, tbl[i].c);
      end

      // ---------------- start ignored while busy ----------------
      a_in = 8'h01; b_in = 8'h01; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      a_in = 8'h80; b_in = 8'h80; start = 1'b1;   // pulse during SHIFT
      step();
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 3 * W && !done; i++) step();
      chk("busy-ign done seen", done, 1'b1);
      start = 1'b1;                               // pulse during DONE
      step();
      start = 1'b0;
      chk("busy-ign idle after done", {busy, done}, 2'b00);
      chk("busy-ign sum", sum, 8'h02);
      chk("busy-ign cout", cout, 1'b0);
      for (int i = 0; i < 2 * W; i++) begin
         if (done) dones++;
         step();
      end
      chk("busy-ign extra dones", dones, 0);
      do_op(8'h80, 8'h80, 1'b0, "after-ign", gs, gc);
      chk("after-ign const", {gc, gs}, 9'h100);

      // ---------------- reset mid-operation ----------------
      a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();                                     // now in SHIFT cycle 4
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("midrst busy", busy, 1'b0);
      chk("midrst sum", sum, 8'h00);
      chk("midrst cout", cout, 1'b0);
      chk("midrst fa", {fa_a, fa_b, fa_ci}, 3'b000);
      dones = 0;
      for (int i = 0; i < 2 * W; i++) begin
         if (done || busy) dones++;
         step();
      end
      chk("midrst no activity", dones, 0);
      do_op(8'h12, 8'h34, 1'b0, "post-rst", gs, gc);
      chk("post-rst const", gs, 8'h46);

      // ---------------- random operations ----------------
      for (int i = 0; i < 40; i++) begin
         sb = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         sb = 1'($urandom_range(0, 1));
`endif
         do_op(W'($urandom), W'($urandom), sb, $sformatf("rnd%0d", i), gs, gc);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
